// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared encodings for the snake game controller:
//   - dir_e    : committed move direction (00 up, 01 right, 10 down, 11 left)
//   - state_e  : game sequencer state (00 IDLE, 01 RUN, 10 PAUSE, 11 OVER)
//   - button indices into the synchronized button vector
//   - dir_opposite(): the reverse of a direction (flip the upper bit)
// -----------------------------------------------------------------------------
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_e;

   localparam int unsigned N_BTN     = 5;
   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_DOWN  = 2;
   localparam int unsigned BTN_LEFT  = 3;
   localparam int unsigned BTN_START = 4;

   // Up<->down and right<->left differ only in bit 1 of the encoding.
   function automatic dir_e dir_opposite(input dir_e d);
      return dir_e'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// Two-flop synchronizer for one asynchronous button, with an optional
// rising-edge pulse taken after the synchronizer.
// Ports:
//   clk      in  : system clock
//   rst_n_i  in  : asynchronous active-low reset
//   async_i  in  : raw (debounced) button, asynchronous to clk
//   level_o  out : synchronized level (2 cycles of latency)
//   rise_o   out : one-cycle pulse on a synchronized 0->1 transition
//                  (tied low when EDGE_EN = 0)
// -----------------------------------------------------------------------------
module btn_sync #(
   parameter bit EDGE_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign level_o = sync_q;

   generate
      if (EDGE_EN) begin : g_edge
         logic prev_q;

         always_ff @(posedge clk or negedge rst_n_i) begin
            if (!rst_n_i) begin
               prev_q <= 1'b0;
            end else begin
               prev_q <= sync_q;
            end
         end

         // Combinational off the synchronized level so that a consumer
         // registering it sees the edge 3 cycles after the raw press.
         assign rise_o = sync_q & ~prev_q;
      end else begin : g_no_edge
         assign rise_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
// Top-level sequencer for the snake game datapath: game state machine,
// speed-dependent tick generator and reversal-proof direction filter.
// Ports:
//   clk          in  : system clock (only clock)
//   reset_n      in  : asynchronous active-low reset (release synchronized)
//   btn_up/right/down/left in : direction buttons, async, active-high
//   btn_start    in  : start/pause button, async, active-high
//   game_over    in  : collision flag from the datapath (synchronous level)
//   score        in  : current snake length
//   game_reset   out : active-high reset to the datapath (high in IDLE)
//   game_tick    out : one-cycle advance pulse
//   move         out : committed direction (snake_pkg::dir_e encoding)
//   state        out : game state (snake_pkg::state_e encoding)
// -----------------------------------------------------------------------------
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned TICK_BASE   = 5_000_000,
   parameter int unsigned TICK_STEP   = 250_000,
   parameter int unsigned TICK_MIN    = 1_000_000,
   parameter int unsigned LEVEL_SHIFT = 2,
   parameter int unsigned SCORE_W     = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               btn_up,
   input  logic               btn_right,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_start,
   input  logic               game_over,
   input  logic [SCORE_W-1:0] score,
   output logic               game_reset,
   output logic               game_tick,
   output logic [1:0]         move,
   output logic [1:0]         state
);

   // Period / counter width, and the wider width used for the arithmetic so
   // that TICK_STEP * level can never wrap before the saturation check.
   localparam int unsigned PW = $clog2(TICK_BASE + 1);
   localparam int unsigned AW = PW + SCORE_W;

   // ---------------------------------------------------------------------
   // Reset: asserts asynchronously, releases on a clock edge.
   // ---------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   // ---------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_rise;
   logic             start_evt;
   logic [4:0]       btn_unused;

   assign btn_raw = {btn_start, btn_left, btn_down, btn_right, btn_up};

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
         btn_sync #(
            .EDGE_EN (gi == BTN_START)
         ) u_btn_sync (
            .clk     (clk),
            .rst_n_i (rst_n),
            .async_i (btn_raw[gi]),
            .level_o (btn_level[gi]),
            .rise_o  (btn_rise[gi])
         );
      end
   endgenerate

   assign start_evt  = btn_rise[BTN_START];
   // Direction edges and the start level have no consumer.
   assign btn_unused = {btn_rise[BTN_LEFT:BTN_UP], btn_level[BTN_START]};

   // ---------------------------------------------------------------------
   // Tick period: max(TICK_MIN, TICK_BASE - TICK_STEP * level), registered
   // ---------------------------------------------------------------------
   logic [SCORE_W-1:0] level;
   logic [AW-1:0]      step_prod;
   logic [AW-1:0]      period_diff;
   logic [PW-1:0]      period_d;
   logic [PW-1:0]      period_q;

   assign level = score >> LEVEL_SHIFT;

   always_comb begin
      step_prod   = AW'(TICK_STEP) * AW'(level);
      period_diff = '0;
      period_d    = PW'(TICK_MIN);
      // A step total at or beyond the base would go negative: saturate.
      if (step_prod < AW'(TICK_BASE)) begin
         period_diff = AW'(TICK_BASE) - step_prod;
         if (period_diff > AW'(TICK_MIN)) begin
            period_d = PW'(period_diff);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= PW'(TICK_BASE);
      end else begin
         period_q <= period_d;
      end
   end

   // ---------------------------------------------------------------------
   // Direction request: priority up > right > down > left
   // ---------------------------------------------------------------------
   logic req_valid;
   dir_e req_dir;

   always_comb begin
      req_valid = |btn_level[BTN_LEFT:BTN_UP];
      req_dir   = DIR_UP;
      if (btn_level[BTN_UP]) begin
         req_dir = DIR_UP;
      end else if (btn_level[BTN_RIGHT]) begin
         req_dir = DIR_RIGHT;
      end else if (btn_level[BTN_DOWN]) begin
         req_dir = DIR_DOWN;
      end else begin
         req_dir = DIR_LEFT;
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer, tick counter and commit
   // ---------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [PW-1:0] cnt_q, cnt_d;
   dir_e          move_q, move_d;
   dir_e          pending_q, pending_d;
   logic          tick_q, tick_d;
   logic          expire;

   // '>=' rather than '==' so a period that shrinks below the running count
   // expires at once instead of wrapping the counter.
   assign expire = (state_q == ST_RUN) && (cnt_q >= (period_q - PW'(1)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      move_d    = move_q;
      pending_d = pending_q;
      tick_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start_evt) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // Compared against the committed move, not pending, so several
            // presses inside one period can never add up to a reversal.
            if (req_valid && (req_dir != dir_opposite(move_q))) begin
               pending_d = req_dir;
            end

            if (game_over) begin
               // Collision wins over both the tick and a pause request.
               state_d = ST_OVER;
            end else begin
               if (expire) begin
                  cnt_d  = '0;
                  move_d = pending_q;
                  tick_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + PW'(1);
               end
               if (start_evt) begin
                  state_d = ST_PAUSE;
               end
            end
         end

         ST_PAUSE: begin
            if (start_evt) begin
               state_d = ST_RUN;
            end
         end

         ST_OVER: begin
            if (start_evt) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         move_q    <= DIR_RIGHT;
         pending_q <= DIR_RIGHT;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         move_q    <= move_d;
         pending_q <= pending_d;
         tick_q    <= tick_d;
      end
   end

   assign state      = state_q;
   assign game_reset = (state_q == ST_IDLE);
   assign game_tick  = tick_q;
   assign move       = move_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_game_ctrl
// Directed bench for snake_game_ctrl with TICK_BASE=20, TICK_STEP=4,
// TICK_MIN=8, LEVEL_SHIFT=1, SCORE_W=6. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_snake_game_ctrl;

   localparam int ST_IDLE  = 0;
   localparam int ST_RUN   = 1;
   localparam int ST_PAUSE = 2;
   localparam int ST_OVER  = 3;

   logic       clk;
   logic       reset_n;
   logic       btn_up, btn_right, btn_down, btn_left, btn_start;
   logic       game_over;
   logic [5:0] score;
   logic       game_reset;
   logic       game_tick;
   logic [1:0] move;
   logic [1:0] state;

   int checks = 0;
   int passes = 0;
   int n;

   snake_game_ctrl #(
      .TICK_BASE   (20),
      .TICK_STEP   (4),
      .TICK_MIN    (8),
      .LEVEL_SHIFT (1),
      .SCORE_W     (6)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_up     (btn_up),
      .btn_right  (btn_right),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_start  (btn_start),
      .game_over  (game_over),
      .score      (score),
      .game_reset (game_reset),
      .game_tick  (game_tick),
      .move       (move),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-26s observed %0d expected %0d", tag, obs, exp);
   endtask

   // Steps falling edges until game_tick is seen; returns the number of
   // edges stepped, or -1 if the bound runs out.
   task automatic wait_tick(input int bound, output int cnt);
      cnt = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         if (game_tick === 1'b1) begin
            cnt = i;
            break;
         end
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      btn_up    = 1'b0;
      btn_right = 1'b0;
      btn_down  = 1'b0;
      btn_left  = 1'b0;
      btn_start = 1'b0;
      game_over = 1'b0;
      score     = 6'd3;

      // Reset state
      step(3);
      chk("rst_state", 32'(state), ST_IDLE);
      chk("rst_game_reset", 32'(game_reset), 1);
      chk("rst_game_tick", 32'(game_tick), 0);
      chk("rst_move", 32'(move), 1);
      reset_n = 1'b1;
      step(4);
      chk("idle_after_release", 32'(state), ST_IDLE);

      // 1: start latency and level-1 period (16)
      btn_start = 1'b1;
      step(2);
      chk("start_lat_2cyc", 32'(state), ST_IDLE);
      step(1);
      chk("start_lat_3cyc", 32'(state), ST_RUN);
      chk("run_game_reset", 32'(game_reset), 0);
      btn_start = 1'b0;
      wait_tick(40, n);
      chk("first_tick_idx", 32'(n), 16);
      wait_tick(40, n);
      chk("tick_period_16", 32'(n), 16);

      // 2: speed-up and clamping
      score = 6'd4;
      wait_tick(40, n);
      chk("tick_period_12a", 32'(n), 12);
      wait_tick(40, n);
      chk("tick_period_12b", 32'(n), 12);
      step(9);
      score = 6'd10;
      wait_tick(40, n);
      chk("shrink_immediate", 32'(n), 2);
      wait_tick(40, n);
      chk("clamp_period_8", 32'(n), 8);
      score = 6'd63;
      wait_tick(40, n);
      chk("max_score_period_8", 32'(n), 8);
      score = 6'd3;
      wait_tick(40, n);
      chk("back_to_period_16", 32'(n), 16);

      // 3: direction filter
      btn_left = 1'b1;
      step(4);
      btn_left = 1'b0;
      wait_tick(40, n);
      chk("left_rejected", 32'(move), 1);
      btn_up = 1'b1;
      step(3);
      btn_up = 1'b0;
      step(2);
      btn_left = 1'b1;
      step(3);
      btn_left = 1'b0;
      wait_tick(40, n);
      chk("up_then_left", 32'(move), 0);
      btn_down = 1'b1;
      btn_left = 1'b1;
      step(3);
      btn_down = 1'b0;
      btn_left = 1'b0;
      wait_tick(40, n);
      chk("down_prio_rejected", 32'(move), 0);
      btn_right = 1'b1;
      step(3);
      btn_right = 1'b0;
      wait_tick(40, n);
      chk("right_accepted", 32'(move), 1);

      // 4: game_over coincident with expiry (count reaches 15 here)
      btn_up = 1'b1;
      step(3);
      btn_up = 1'b0;
      step(12);
      game_over = 1'b1;
      step(1);
      chk("over_no_tick", 32'(game_tick), 0);
      chk("over_state", 32'(state), ST_OVER);
      chk("over_move_kept", 32'(move), 1);
      chk("over_game_reset", 32'(game_reset), 0);
      game_over = 1'b0;
      wait_tick(40, n);
      chk("over_no_ticks", 32'(n), 32'hFFFF_FFFF);
      btn_start = 1'b1;
      step(3);
      chk("over_to_idle", 32'(state), ST_IDLE);
      chk("idle_game_reset", 32'(game_reset), 1);
      btn_start = 1'b0;
      step(4);
      btn_start = 1'b1;
      step(3);
      chk("restart_run", 32'(state), ST_RUN);
      chk("restart_move", 32'(move), 1);
      btn_start = 1'b0;
      wait_tick(40, n);
      chk("restart_first_tick", 32'(n), 16);
      chk("restart_pending_up", 32'(move), 0);

      // 5: pause with the counter held at 7
      step(4);
      btn_start = 1'b1;
      step(3);
      chk("pause_state", 32'(state), ST_PAUSE);
      btn_start = 1'b0;
      btn_left  = 1'b1;
      step(5);
      btn_left  = 1'b0;
      wait_tick(200, n);
      chk("pause_no_ticks", 32'(n), 32'hFFFF_FFFF);
      chk("pause_still", 32'(state), ST_PAUSE);
      btn_start = 1'b1;
      step(3);
      chk("resume_run", 32'(state), ST_RUN);
      btn_start = 1'b0;
      wait_tick(40, n);
      chk("resume_remaining", 32'(n), 9);
      chk("pause_dir_ignored", 32'(move), 0);

      // start_evt coincident with expiry: pause, tick still emitted
      step(13);
      btn_start = 1'b1;
      step(3);
      chk("start_expire_pause", 32'(state), ST_PAUSE);
      chk("start_expire_tick", 32'(game_tick), 1);
      btn_start = 1'b0;
      step(3);
      btn_start = 1'b1;
      step(3);
      btn_start = 1'b0;
      wait_tick(40, n);
      chk("resume_after_tick", 32'(n), 16);

      // 6: asynchronous reset during a tick cycle
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_tick", 32'(game_tick), 0);
      chk("async_rst_state", 32'(state), ST_IDLE);
      chk("async_rst_game_reset", 32'(game_reset), 1);
      chk("async_rst_move", 32'(move), 1);
      @(negedge clk);
      reset_n = 1'b1;
      step(4);
      chk("post_rst_idle", 32'(state), ST_IDLE);
      btn_start = 1'b1;
      step(3);
      chk("post_rst_run", 32'(state), ST_RUN);
      btn_start = 1'b0;
      wait_tick(40, n);
      chk("post_rst_first_tick", 32'(n), 16);
      chk("post_rst_move", 32'(move), 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Top-level sequencer for the snake game datapath. Owns the game state (idle, running, paused, over) and holds the datapath in reset between games. Generates the single-cycle `game_tick` that advances the snake, speeding up as `score` rises. Filters the player's direction buttons into a legal `move` command that never reverses the snake onto itself.

## Interface
Parameters:
- `TICK_BASE`, 5_000_000: tick period in clk cycles at level 0.
- `TICK_STEP`, 250_000: period reduction per level.
- `TICK_MIN`, 1_000_000: lower clamp on the period.
- `LEVEL_SHIFT`, 2: level = `score >> LEVEL_SHIFT`.
- `SCORE_W`, 10: width of `score`.

Ports:
- `clk`  in  1: system clock; the block's only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `btn_up`, `btn_right`, `btn_down`, `btn_left`  in  1 each: debounced direction buttons, asynchronous to clk, active-high.
- `btn_start`  in  1: debounced start/pause button, asynchronous, active-high.
- `game_over`  in  1: collision flag from the datapath, level, synchronous.
- `score`  in  SCORE_W: current snake length from the datapath.
- `game_reset`  out  1: active-high synchronous reset to the datapath.
- `game_tick`  out  1: one-cycle advance pulse.
- `move`  out  2: committed direction; 00 up, 01 right, 10 down, 11 left.
- `state`  out  2: 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.

## Operation
Input conditioning:
- All five buttons pass through two-flop synchronizers.
- `btn_start` also feeds a rising-edge detector, producing `start_evt`.

State machine:
- IDLE: `game_reset`=1. `start_evt` → RUN.
- RUN: `game_reset`=0 and the tick counter runs.
  - `game_over`=1 → OVER. This takes priority over `start_evt` and over counter expiry.
  - Otherwise `start_evt` → PAUSE.
- PAUSE: counter value and `pending` are frozen and direction buttons are ignored. `start_evt` → RUN, and counting resumes from the held value.
- OVER: no ticks; `game_reset` stays 0 so the final board remains displayed. `start_evt` → IDLE. Starting a new game therefore takes two presses.

Tick period:
- `period_r` is registered every cycle (1-cycle latency) as `max(TICK_MIN, TICK_BASE − TICK_STEP·level)`.
- The product and subtraction are computed at width `clog2(TICK_BASE+1)+SCORE_W`.
- A negative result saturates to TICK_MIN.

Tick counter:
- Clears to 0 on entry to RUN from IDLE.
- Increments each RUN cycle.
- On `count >= period_r−1`, raises `expire` and clears. Using `>=` means a shrinking period mid-count takes effect immediately, with no wrap.

Direction filter:
- Requested direction uses priority up > right > down > left when several buttons are held.
- A request is accepted into `pending` only in RUN, and only if it is not the opposite (`req ^ 2'b10`) of the committed `move`.
- The check is against `move`, not `pending`, so two presses within one period cannot produce a reversal.

Commit and tick:
- On `expire`: `move <= pending`.
- The next cycle: `game_tick`=1.

## Timing
Reset values (async assert, release synchronized to clk):
- `state`=IDLE, `game_reset`=1, `game_tick`=0, `move`=01, `pending`=01, counter=0, `period_r`=TICK_BASE.

Latencies:
- `btn_start` rising edge to state change: 3 cycles (2 sync + 1 register).
- Counter expiry to `game_tick`: 1 cycle. `move` is stable during the tick cycle and for at least `period_r−1` cycles after it.
- First tick after IDLE→RUN lands on RUN cycle index `period_r` (counting from 0); subsequent ticks are exactly `period_r` cycles apart.

Boundary cases:
- `game_over` coincident with `expire`: no `game_tick`, `move` unchanged, state → OVER.
- `start_evt` coincident with `expire` in RUN: enter PAUSE, and the pending tick is still emitted the next cycle.
- `reset_n` asserted mid-game: all outputs return to reset values in the same cycle, asynchronously.
- `score` reaching its maximum value: the period clamps at TICK_MIN with no overflow.

## Structure
- Shared package `snake_pkg` holds:
  - `move` encodings (`DIR_UP`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT`) and the opposite-direction rule.
  - `state` encodings.
- One sub-module, `btn_sync`: a two-flop synchronizer with an optional rising-edge output, instantiated five times.
- Period arithmetic, FSM, counter and direction filter all live in `snake_game_ctrl`.

## Test plan
Bench parameters for all scenarios: TICK_BASE=20, TICK_STEP=4, TICK_MIN=8, LEVEL_SHIFT=1, SCORE_W=6.

1. Reset, hold `score`=3, pulse start → `state`=RUN 3 cycles after the press, `game_reset` falls, first `game_tick` at RUN index 16, then every 16 cycles (level 1, period 16).
2. Raise `score` from 4 to 10 mid-run → period 12 at `score`=4. At `score`=10 the computed value is 0, clamped to 8. The next tick arrives no later than 8 cycles after `period_r` updates.
3. `move`=01 (right); press left → rejected, `pending` stays 01. Press up, then left, within one period → at the next tick `move`=00 (up), and left is still rejected.
4. Assert `game_over` in the same cycle as expiry → no `game_tick`, `state`=OVER. Press start → IDLE with `game_reset`=1. Press start again → RUN with `move`=01 kept from before.
5. Press start at counter value 7 → PAUSE, no ticks for 200 cycles, direction presses ignored. Press start → RUN, next tick after the remaining cycles (period − 7 ± sync latency, checked exactly against the model).
6. Drop `reset_n` mid-RUN, asynchronously to clk → outputs take reset values before the next clk edge. Release → IDLE.
